// File: rtl/int_to_fp_lane_sched.sv
// -----------------------------------------------------------------------------
// int_to_fp_lane_sched
//   Serialises a SOFT_THREAD-lane integer-to-float request onto one scalar
//   int-to-fp unit. Active lanes are issued lowest index first. Results come
//   back in issue order, are written into their lane slots, and their flags
//   are ORed together. The complete vector is then returned with a
//   valid/ready handshake.
//
// Parameters
//   SOFT_THREAD : lanes per vector request
//   WARP_W      : width of the warp-id control field
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o     request handshake (ready only when idle)
//   op_i, rm_i, a_i, vecmask_i  conversion op, rounding mode, lane operands,
//                               active-lane mask
//   out_valid_o / out_ready_i   result handshake
//   result_o, fflags_o          per-lane results, OR of active-lane flags
//   vecmask_o                   mask of the returned request
//   u_in_valid_o / u_in_ready_i issue handshake to the scalar unit
//   u_op_o, u_rm_o, u_a_o       scalar operands (lane widened to 64 bits)
//   u_out_valid_i/u_out_ready_o result handshake from the scalar unit
//   u_result_i, u_fflags_i      scalar result (low 32 bits) and flags
//
// Optional feature (macro INT2FP_SCHED_CTRL_EN)
//   Adds ctrl_regindex_i/o, ctrl_warpid_i/o, ctrl_wvd_i/o and ctrl_wxd_i/o.
//   These fields are captured when a request is accepted and are presented
//   with the result.
// -----------------------------------------------------------------------------
module int_to_fp_lane_sched #(
  parameter int SOFT_THREAD = 4,
  parameter int WARP_W      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [2:0]                op_i,
  input  logic [2:0]                rm_i,
  input  logic [SOFT_THREAD*32-1:0] a_i,
  input  logic [SOFT_THREAD-1:0]    vecmask_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [SOFT_THREAD*32-1:0] result_o,
  output logic [4:0]                fflags_o,
  output logic [SOFT_THREAD-1:0]    vecmask_o,
  output logic                      u_in_valid_o,
  input  logic                      u_in_ready_i,
  output logic [2:0]                u_op_o,
  output logic [2:0]                u_rm_o,
  output logic [63:0]               u_a_o,
  input  logic                      u_out_valid_i,
  output logic                      u_out_ready_o,
  input  logic [63:0]               u_result_i,
  input  logic [4:0]                u_fflags_i
`ifdef INT2FP_SCHED_CTRL_EN
  ,
  input  logic [4:0]                ctrl_regindex_i,
  output logic [4:0]                ctrl_regindex_o,
  input  logic [WARP_W-1:0]         ctrl_warpid_i,
  output logic [WARP_W-1:0]         ctrl_warpid_o,
  input  logic                      ctrl_wvd_i,
  output logic                      ctrl_wvd_o,
  input  logic                      ctrl_wxd_i,
  output logic                      ctrl_wxd_o
`endif
);

  localparam int LANE_W = (SOFT_THREAD > 1) ? $clog2(SOFT_THREAD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_r, state_n;
  logic [2:0]                op_r, rm_r;
  logic [SOFT_THREAD*32-1:0] a_r, result_r;
  logic [SOFT_THREAD-1:0]    mask_r;
  logic [SOFT_THREAD-1:0]    iss_mask_r, iss_mask_n_s;  // lanes still to issue
  logic [SOFT_THREAD-1:0]    ret_mask_r, ret_mask_n_s;  // lanes still awaiting a result
  logic [4:0]                fflags_r;
  logic [LANE_W-1:0]         iss_lane_s, ret_lane_s;
  logic [31:0]               lane_word_s;
  logic                      accept_s, issue_fire_s, ret_fire_s;
  logic [31:0]               unused_result_hi_s;

  // Index of the lowest set bit; results return in issue order, so this
  // same selection serves both the issue side and the return side.
  function automatic logic [LANE_W-1:0] lowest_set(input logic [SOFT_THREAD-1:0] m);
    lowest_set = {LANE_W{1'b0}};
    for (int k = SOFT_THREAD - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = LANE_W'(k);
    end
  endfunction

  assign iss_lane_s         = lowest_set(iss_mask_r);
  assign ret_lane_s         = lowest_set(ret_mask_r);
  assign accept_s           = (state_r == S_IDLE) && in_valid_i;
  assign issue_fire_s       = (state_r == S_ISSUE) && u_in_ready_i;
  assign ret_fire_s         = ((state_r == S_ISSUE) || (state_r == S_DRAIN)) &&
                              u_out_valid_i && (ret_mask_r != {SOFT_THREAD{1'b0}});
  assign unused_result_hi_s = u_result_i[63:32];

  // Operands to the unit come only from registers, so they cannot change
  // while an issue is stalled.
  assign lane_word_s = a_r[{iss_lane_s, 5'b00000} +: 32];
  assign u_a_o       = {(op_r[0] ? {32{lane_word_s[31]}} : 32'h0000_0000), lane_word_s};
  assign u_op_o      = op_r;
  assign u_rm_o      = rm_r;
  assign result_o    = result_r;
  assign fflags_o    = fflags_r;
  assign vecmask_o   = mask_r;

  // Retire the issued lane and the returned lane from their pending masks.
  always_comb begin
    iss_mask_n_s = iss_mask_r;
    ret_mask_n_s = ret_mask_r;
    if (issue_fire_s) begin
      iss_mask_n_s = iss_mask_r & ~(SOFT_THREAD'(1'b1) << iss_lane_s);
    end else begin
      iss_mask_n_s = iss_mask_r;
    end
    if (ret_fire_s) begin
      ret_mask_n_s = ret_mask_r & ~(SOFT_THREAD'(1'b1) << ret_lane_s);
    end else begin
      ret_mask_n_s = ret_mask_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_n       = state_r;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    u_in_valid_o  = 1'b0;
    u_out_ready_o = 1'b0;
    case (state_r)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (vecmask_i != {SOFT_THREAD{1'b0}}) begin
            state_n = S_ISSUE;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ISSUE: begin
        u_in_valid_o  = 1'b1;
        u_out_ready_o = 1'b1;
        if (iss_mask_n_s == {SOFT_THREAD{1'b0}}) begin
          if (ret_mask_n_s != {SOFT_THREAD{1'b0}}) begin
            state_n = S_DRAIN;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          state_n = S_ISSUE;
        end
      end
      S_DRAIN: begin
        u_out_ready_o = 1'b1;
        if (ret_mask_n_s == {SOFT_THREAD{1'b0}}) begin
          state_n = S_DONE;
        end else begin
          state_n = S_DRAIN;
        end
      end
      S_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Request capture, lane bookkeeping and result/flag accumulation.
  // Results are cleared at accept, so masked-off lanes return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 3'b000;
      rm_r       <= 3'b000;
      a_r        <= {(SOFT_THREAD*32){1'b0}};
      mask_r     <= {SOFT_THREAD{1'b0}};
      iss_mask_r <= {SOFT_THREAD{1'b0}};
      ret_mask_r <= {SOFT_THREAD{1'b0}};
      result_r   <= {(SOFT_THREAD*32){1'b0}};
      fflags_r   <= 5'b00000;
    end else if (accept_s) begin
      op_r       <= op_i;
      rm_r       <= rm_i;
      a_r        <= a_i;
      mask_r     <= vecmask_i;
      iss_mask_r <= vecmask_i;
      ret_mask_r <= vecmask_i;
      result_r   <= {(SOFT_THREAD*32){1'b0}};
      fflags_r   <= 5'b00000;
    end else begin
      iss_mask_r <= iss_mask_n_s;
      ret_mask_r <= ret_mask_n_s;
      if (ret_fire_s) begin
        result_r[{ret_lane_s, 5'b00000} +: 32] <= u_result_i[31:0];
        fflags_r                               <= fflags_r | u_fflags_i;
      end
    end
  end

`ifdef INT2FP_SCHED_CTRL_EN
  logic [4:0]        regindex_r;
  logic [WARP_W-1:0] warpid_r;
  logic              wvd_r, wxd_r;

  // Side-band control fields travel with the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regindex_r <= 5'b00000;
      warpid_r   <= {WARP_W{1'b0}};
      wvd_r      <= 1'b0;
      wxd_r      <= 1'b0;
    end else if (accept_s) begin
      regindex_r <= ctrl_regindex_i;
      warpid_r   <= ctrl_warpid_i;
      wvd_r      <= ctrl_wvd_i;
      wxd_r      <= ctrl_wxd_i;
    end
  end

  assign ctrl_regindex_o = regindex_r;
  assign ctrl_warpid_o   = warpid_r;
  assign ctrl_wvd_o      = wvd_r;
  assign ctrl_wxd_o      = wxd_r;
`else
  logic [WARP_W-1:0] unused_warpid_s;
  assign unused_warpid_s = {WARP_W{1'b0}};
`endif

endmodule

// File: tb/tb_int_to_fp_lane_sched.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp_lane_sched
//   Directed bench for int_to_fp_lane_sched (SOFT_THREAD=4). A behavioural
//   two-cycle int-to-fp unit answers the scheduler. It performs a real
//   int -> fp32 conversion with round-to-nearest-even and raises NX on
//   inexact results. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_int_to_fp_lane_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_i, in_ready_o;
  logic [2:0]   op_i, rm_i;
  logic [127:0] a_i;
  logic [3:0]   vecmask_i;
  logic         out_valid_o, out_ready_i;
  logic [127:0] result_o;
  logic [4:0]   fflags_o;
  logic [3:0]   vecmask_o;
  logic         u_in_valid_o, u_in_ready_i;
  logic [2:0]   u_op_o, u_rm_o;
  logic [63:0]  u_a_o;
  logic         u_out_valid_i, u_out_ready_o;
  logic [63:0]  u_result_i;
  logic [4:0]   u_fflags_i;
`ifdef INT2FP_SCHED_CTRL_EN
  logic [4:0]   ctrl_regindex_o;
  logic [2:0]   ctrl_warpid_o;
  logic         ctrl_wvd_o, ctrl_wxd_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int issue_cnt = 0;
  int uv_cnt    = 0;
  logic [63:0] ua_log [0:63];

  localparam logic [2:0] OP_U32 = 3'b000;
  localparam logic [2:0] OP_S32 = 3'b001;

  int_to_fp_lane_sched #(.SOFT_THREAD(4), .WARP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rm_i(rm_i), .a_i(a_i), .vecmask_i(vecmask_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .fflags_o(fflags_o), .vecmask_o(vecmask_o),
    .u_in_valid_o(u_in_valid_o), .u_in_ready_i(u_in_ready_i),
    .u_op_o(u_op_o), .u_rm_o(u_rm_o), .u_a_o(u_a_o),
    .u_out_valid_i(u_out_valid_i), .u_out_ready_o(u_out_ready_o),
    .u_result_i(u_result_i), .u_fflags_i(u_fflags_i)
`ifdef INT2FP_SCHED_CTRL_EN
    ,
    .ctrl_regindex_i(5'd9), .ctrl_regindex_o(ctrl_regindex_o),
    .ctrl_warpid_i(3'd5), .ctrl_warpid_o(ctrl_warpid_o),
    .ctrl_wvd_i(1'b1), .ctrl_wvd_o(ctrl_wvd_o),
    .ctrl_wxd_i(1'b0), .ctrl_wxd_o(ctrl_wxd_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue log: the operand of every accepted issue, plus valid-high cycles.
  always @(posedge clk) begin
    if (u_in_valid_o) uv_cnt <= uv_cnt + 1;
    if (u_in_valid_o && u_in_ready_i) begin
      ua_log[issue_cnt[5:0]] <= u_a_o;
      issue_cnt <= issue_cnt + 1;
    end
  end

  // Reference int -> fp32 conversion (RNE), returns {flags, fp32}.
  function automatic logic [36:0] cvt(input logic [63:0] a, input logic sgn);
    logic        neg, nx;
    logic [63:0] mag, kept, rem, half;
    logic [8:0]  e;
    int          msb, sh;
    neg = sgn & a[63];
    mag = neg ? (~a + 64'd1) : a;
    if (mag == 64'd0) return 37'd0;
    msb = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
    e  = 9'(msb + 127);
    nx = 1'b0;
    if (msb <= 23) begin
      kept = mag << (23 - msb);
    end else begin
      sh   = msb - 23;
      kept = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      nx   = (rem != 64'd0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (kept[24]) begin
        kept = kept >> 1;
        e    = e + 9'd1;
      end
    end
    return {4'b0000, nx, neg, e[7:0], kept[22:0]};
  endfunction

  // Behavioural two-stage unit: issued in cycle t, result offered in t+2.
  logic        p1_v, p2_v;
  logic [36:0] p1_d, p2_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= 37'd0; p2_d <= 37'd0;
    end else begin
      p2_v <= p1_v;
      p2_d <= p1_d;
      p1_v <= u_in_valid_o && u_in_ready_i;
      p1_d <= cvt(u_a_o, u_op_o[0]);
    end
  end
  assign u_out_valid_i = p2_v;
  assign u_result_i    = {32'hDEAD_BEEF, p2_d[31:0]};
  assign u_fflags_i    = p2_d[36:32];

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request and return just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [3:0] mask, input logic [127:0] a);
    @(negedge clk);
    op_i = op; rm_i = 3'b000; a_i = a; vecmask_i = mask; in_valid_i = 1'b1;
    check_val("in_ready_before_accept", {127'd0, in_ready_o}, 128'd1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    a_i        = ~a;  // operands must have been latched
    t_acc      = cyc;
  endtask

  // Call at a negedge; waits (bounded) for out_valid_o and checks latency.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid_o) begin
        lat = cyc - t_acc + 1;
        break;
      end
      @(negedge clk);
    end
    check_val(tag, 128'(lat), 128'(exp_lat));
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    check_val("idle_after_handoff", {126'd0, in_ready_o, out_valid_o}, 128'b10);
  endtask

  int base_i, base_uv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; op_i = 3'b000; rm_i = 3'b000; a_i = 128'd0;
    vecmask_i = 4'b0000; out_ready_i = 1'b0; u_in_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_state", {in_ready_o, out_valid_o, u_in_valid_o, u_out_ready_o, fflags_o, vecmask_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
    check_val("reset_result", result_o, 128'd0);
    rst_n = 1'b1;

    // Full mask, signed 1,2,3,-4.
    base_i = issue_cnt;
    send(OP_S32, 4'b1111, {32'hFFFF_FFFC, 32'd3, 32'd2, 32'd1});
    @(negedge clk);
    wait_done("full_latency", 7);
    check_val("full_result", result_o, {32'hC080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
    check_val("full_fflags", 128'(fflags_o), 128'd0);
    check_val("full_vecmask", 128'(vecmask_o), 128'hF);
    check_val("full_issues", 128'(issue_cnt - base_i), 128'd4);
    check_val("sign_ext_lane3", 128'(ua_log[base_i[5:0] + 6'd3]), 128'hFFFF_FFFF_FFFF_FFFC);
    handoff();

    // Sparse mask 0101: masked lanes carry nonzero operands but read 0.
    base_i = issue_cnt;
    send(OP_S32, 4'b0101, {32'd11, 32'd7, 32'd9, 32'd5});
    @(negedge clk);
    wait_done("sparse_latency", 5);
    check_val("sparse_result", result_o, {32'd0, 32'h40E0_0000, 32'd0, 32'h40A0_0000});
    check_val("sparse_issues", 128'(issue_cnt - base_i), 128'd2);
    // Hold in DONE for five cycles with a competing request pending.
    in_valid_i = 1'b1; vecmask_i = 4'b1111; a_i = 128'd1;
    for (int k = 0; k < 5; k++) begin
      check_val("hold_ctrl", {125'd0, out_valid_o, in_ready_o, u_in_valid_o}, 128'b100);
      check_val("hold_result", result_o, {32'd0, 32'h40E0_0000, 32'd0, 32'h40A0_0000});
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    check_val("hold_no_accept", {124'd0, vecmask_o}, 128'h5);
    handoff();

    // Empty mask: completes immediately with no issue.
    base_uv = uv_cnt;
    send(OP_S32, 4'b0000, {32'd1, 32'd2, 32'd3, 32'd4});
    @(negedge clk);
    wait_done("empty_latency", 1);
    check_val("empty_result", {result_o[122:0], fflags_o}, 128'd0);
    check_val("empty_no_issue", 128'(uv_cnt - base_uv), 128'd0);
    handoff();

    // Unsigned 0xFFFFFFFF and 0x01000001: zero extension, rounding, NX.
    base_i = issue_cnt;
    send(OP_U32, 4'b0011, {32'd0, 32'd0, 32'h0100_0001, 32'hFFFF_FFFF});
    @(negedge clk);
    wait_done("unsigned_latency", 5);
    check_val("unsigned_result", result_o, {32'd0, 32'd0, 32'h4B80_0000, 32'h4F80_0000});
    check_val("unsigned_fflags", 128'(fflags_o), 128'h01);
    check_val("zero_ext_lane0", 128'(ua_log[base_i[5:0]]), 128'h0000_0000_FFFF_FFFF);
    handoff();

    // Issue stalled for three cycles after lane 0.
    base_i = issue_cnt;
    send(OP_S32, 4'b1111, {32'd40, 32'd30, 32'd20, 32'd10});
    @(negedge clk);
    @(negedge clk);
    u_in_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("stall_u_a_stable", {63'd0, u_in_valid_o, u_a_o}, {63'd0, 1'b1, 64'd20});
      @(negedge clk);
    end
    check_val("stall_issue_count", 128'(issue_cnt - base_i), 128'd1);
    u_in_ready_i = 1'b1;
    wait_done("stall_latency", 10);
    check_val("stall_result", result_o, {32'h4220_0000, 32'h41F0_0000, 32'h41A0_0000, 32'h4120_0000});
    handoff();

    // Reset while stuck in ISSUE.
    u_in_ready_i = 1'b0;
    send(OP_S32, 4'b1111, {32'd1, 32'd2, 32'd3, 32'd4});
    @(negedge clk);
    check_val("stuck_in_issue", {127'd0, u_in_valid_o}, 128'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", {in_ready_o, out_valid_o, u_in_valid_o, u_out_ready_o, fflags_o, vecmask_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    u_in_ready_i = 1'b1;
    @(negedge clk);
    check_val("post_reset_idle", {in_ready_o, out_valid_o, u_in_valid_o, u_out_ready_o, fflags_o, vecmask_o},
              {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});
    check_val("post_reset_result", result_o, 128'd0);

    // Single top lane after reset; no stale result may land.
    base_i = issue_cnt;
    send(OP_S32, 4'b1000, {32'hFFFF_FFFF, 32'd6, 32'd6, 32'd6});
    @(negedge clk);
    wait_done("single_latency", 4);
    check_val("single_result", result_o, {32'hBF80_0000, 32'd0, 32'd0, 32'd0});
    check_val("single_issues", 128'(issue_cnt - base_i), 128'd1);
    handoff();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
